// File: rtl/mac_result_buf.sv
// Result byte FIFO between the systolic MAC and the output pins, popped by a slow host pin.
// Optional debug peek port enabled by defining RESULT_BUF_DBG_EN.
module mac_result_buf #(
    parameter int W      = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr_i,
    input  logic              result_v_i,
    input  logic [W-1:0]      result_i,
    input  logic              rd_req_i,
    output logic              out_v_o,
    output logic [W-1:0]      out_o,
    output logic              full_o,
    output logic              ovf_o,
    output logic [ADDR_W:0]   level_o
`ifdef RESULT_BUF_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [W-1:0]      dbg_data_o
`endif
);

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              ovf;
    logic              sync1;
    logic              sync2;
    logic              sync3;

    logic pop_req;
    logic push;
    logic pop;
    logic empty;
    logic full;
    logic do_write;
    logic ovf_set;

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_FULL);
    assign pop_req  = sync2 & ~sync3;
    assign push     = ena & result_v_i;
    assign pop      = ena & pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_write = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    // Pin synchronizer plus edge-detect flop; frozen with ena, untouched by clr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else if (ena) begin
            sync1 <= rd_req_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_write, pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage survives clr_i; only a reset wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!clr_i && do_write) begin
            mem[wr_ptr] <= result_i;
        end
    end

    assign out_v_o = ~empty;
    assign out_o   = mem[rd_ptr];
    assign full_o  = full;
    assign ovf_o   = ovf;
    assign level_o = level;

`ifdef RESULT_BUF_DBG_EN
    logic [ADDR_W-1:0] peek_idx;
    logic              peek_hit;

    assign peek_idx   = rd_ptr + dbg_addr_i;
    assign peek_hit   = ({1'b0, dbg_addr_i} < level);
    assign dbg_data_o = peek_hit ? mem[peek_idx] : {ovf, full, (W-2)'(level)};
`endif

endmodule

// File: tb/tb_mac_result_buf.sv
// Bench for mac_result_buf: directed scenarios plus random traffic against a queue-based model.
// Define RESULT_BUF_DBG_EN to also exercise the debug peek port.
module tb_mac_result_buf;
    localparam int W      = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              clr_i = 1'b0;
    logic              result_v_i = 1'b0;
    logic [W-1:0]      result_i = '0;
    logic              rd_req_i = 1'b0;
    logic              out_v_o;
    logic [W-1:0]      out_o;
    logic              full_o;
    logic              ovf_o;
    logic [ADDR_W:0]   level_o;
`ifdef RESULT_BUF_DBG_EN
    logic [ADDR_W-1:0] dbg_addr_i = '0;
    logic [W-1:0]      dbg_data_o;
`endif

    always #5 clk = ~clk;

    mac_result_buf #(.W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clr_i      (clr_i),
        .result_v_i (result_v_i),
        .result_i   (result_i),
        .rd_req_i   (rd_req_i),
        .out_v_o    (out_v_o),
        .out_o      (out_o),
        .full_o     (full_o),
        .ovf_o      (ovf_o),
        .level_o    (level_o)
`ifdef RESULT_BUF_DBG_EN
        ,
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: scoreboard queue of accepted bytes, sticky overflow, and the pin
    // values seen on the last three enabled clock edges (newest first).
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;
    logic         pin_s0 = 1'b0;
    logic         pin_s1 = 1'b0;
    logic         pin_s2 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            pin_s0 = 1'b0;
            pin_s1 = 1'b0;
            pin_s2 = 1'b0;
        end else begin
            // A rising pin is acted on once it has been seen high two enabled edges back.
            logic rise_seen;
            rise_seen = pin_s1 && !pin_s2;
            if (clr_i) begin
                exp_q.delete();
                m_ovf = 1'b0;
            end else if (ena) begin
                if (rise_seen && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                if (result_v_i) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(result_i);
                    else                      m_ovf = 1'b1;
                end
            end
            if (ena) begin
                pin_s2 = pin_s1;
                pin_s1 = pin_s0;
                pin_s0 = rd_req_i;
            end
        end
    end

    // Monitor: compares the presented head and flags against the model every cycle.
    always @(negedge clk) begin
        check("level", 32'(level_o), 32'(exp_q.size()));
        check("out_v", 32'(out_v_o), 32'(exp_q.size() != 0));
        check("full", 32'(full_o), 32'(exp_q.size() == DEPTH));
        check("ovf", 32'(ovf_o), 32'(m_ovf));
        if (exp_q.size() != 0) check("out_head", 32'(out_o), 32'(exp_q[0]));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [W-1:0] b);
        result_v_i = 1'b1;
        result_i   = b;
        cyc(1);
        result_v_i = 1'b0;
    endtask

    task automatic pulse();
        rd_req_i = 1'b1;
        cyc(4);
        rd_req_i = 1'b0;
        cyc(4);
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] drain_exp [4];
        int p_push;

        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_level", 32'(level_o), 0);
        check("rst_out", 32'(out_o), 0);
        check("rst_out_v", 32'(out_v_o), 0);

        // Reset mid-stream discards contents immediately
        result_v_i = 1'b1;
        result_i = 8'h01; cyc(1);
        result_i = 8'h02; cyc(1);
        result_i = 8'h03; cyc(1);
        result_v_i = 1'b0;
        check("pre_rst_level", 32'(level_o), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level_o), 0);
        check("async_rst_out", 32'(out_o), 0);
        check("async_rst_out_v", 32'(out_v_o), 0);
        check("async_rst_full", 32'(full_o), 0);
        check("async_rst_ovf", 32'(ovf_o), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_level", 32'(level_o), 0);

        // Fill and overflow
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        check("fill_full", 32'(full_o), 1);
        check("fill_level", 32'(level_o), 4);
        check("fill_out", 32'(out_o), 8'h11);
        push_byte(8'h55);
        check("ovf_set", 32'(ovf_o), 1);
        check("ovf_level", 32'(level_o), 4);
        check("ovf_out", 32'(out_o), 8'h11);

        // Pin rise pops on the third edge; holding high pops only once
        rd_req_i = 1'b1;
        @(posedge clk); #1 check("pop_edge1", 32'(level_o), 4);
        @(posedge clk); #1 check("pop_edge2", 32'(level_o), 4);
        @(posedge clk); #1 check("pop_edge3", 32'(level_o), 3);
        check("pop_out", 32'(out_o), 8'h22);
        cyc(20);
        check("hold_level", 32'(level_o), 3);
        rd_req_i = 1'b0;
        cyc(3);
        repeat (4) pulse();
        check("drained_out_v", 32'(out_v_o), 0);
        check("drained_level", 32'(level_o), 0);
        pulse();
        check("empty_pop_level", 32'(level_o), 0);
        check("empty_pop_ovf", 32'(ovf_o), 1);

        // Push coincident with pop while full
        do_clear();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        rd_req_i = 1'b1;
        cyc(2);
        result_v_i = 1'b1;
        result_i   = 8'h66;
        cyc(1);
        result_v_i = 1'b0;
        check("pp_level", 32'(level_o), 4);
        check("pp_ovf", 32'(ovf_o), 0);
        check("pp_out", 32'(out_o), 8'h22);
        rd_req_i = 1'b0;
        cyc(3);
        drain_exp[0] = 8'h22; drain_exp[1] = 8'h33; drain_exp[2] = 8'h44; drain_exp[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(out_o), 32'(drain_exp[i]));
            pulse();
        end
        check("drain_done", 32'(out_v_o), 0);

        // ena low freezes everything; clr_i still works
        push_byte(8'h77); push_byte(8'h88); push_byte(8'h99); push_byte(8'hAA); push_byte(8'hBB);
        ena = 1'b0;
        result_v_i = 1'b1;
        result_i = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            rd_req_i = ~rd_req_i;
            cyc(1);
        end
        result_v_i = 1'b0;
        rd_req_i = 1'b0;
        check("frozen_level", 32'(level_o), 4);
        check("frozen_out", 32'(out_o), 8'h77);
        check("frozen_ovf", 32'(ovf_o), 1);
        do_clear();
        check("clr_level", 32'(level_o), 0);
        check("clr_ovf", 32'(ovf_o), 0);
        check("clr_out_v", 32'(out_v_o), 0);
        ena = 1'b1;
        cyc(4);

`ifdef RESULT_BUF_DBG_EN
        do_clear();
        cyc(4);
        push_byte(8'hA1); push_byte(8'hB2);
        dbg_addr_i = 2'd1; #1 check("dbg_peek1", 32'(dbg_data_o), 8'hB2);
        dbg_addr_i = 2'd0; #1 check("dbg_peek0", 32'(dbg_data_o), 8'hA1);
        dbg_addr_i = 2'd3; #1 check("dbg_status", 32'(dbg_data_o), 8'h02);
        cyc(2);
        check("dbg_level", 32'(level_o), 2);
        push_byte(8'hC3); push_byte(8'hD4); push_byte(8'hE5);
        dbg_addr_i = 2'd3; #1 check("dbg_peek_full", 32'(dbg_data_o), 8'hD4);
        dbg_addr_i = 2'd0;
        do_clear();
`endif

        // Random traffic in phases alternating fill-heavy and drain-heavy
        for (int ph = 0; ph < 8; ph++) begin
            p_push = (ph % 2 == 0) ? 60 : 10;
            for (int c = 0; c < 400; c++) begin
                ena        = ($urandom_range(0, 9) != 0);
                result_v_i = ($urandom_range(0, 99) < p_push);
                result_i   = W'($urandom);
                clr_i      = ($urandom_range(0, 127) == 0);
                if ($urandom_range(0, 2) == 0) rd_req_i = ~rd_req_i;
                if ($urandom_range(0, 399) == 0) begin
                    #2 rst_n = 1'b0;
                    #1 check("rand_rst_out", 32'(out_o), 0);
                    cyc(1);
                    rst_n = 1'b1;
                end else begin
                    cyc(1);
                end
            end
        end
        ena = 1'b1;
        result_v_i = 1'b0;
        clr_i = 1'b0;
        rd_req_i = 1'b0;
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
